mod_n_updown_counter: RTL
=========================

Name: mod_n_updown_counter

Overview:
- Parametrised successor to the team's free-running 4-bit counter: WIDTH-bit modulo-MODULUS up/down counter.
- Adds count enable, direction, synchronous clear and load, wrap or saturate mode, terminal-count and wrap flags, and a sticky overflow flag.
- Used as a general-purpose event/timebase counter; cascadable through wrap_o.

Parameters:
- WIDTH, 4, counter width in bits (2..32)
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH
- PRESCALE, 4, enabled cycles per count step; used only with the optional feature (>=1)

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous active-high reset
- en_i  input  1  count enable
- up_i  input  1  1 = count up, 0 = count down
- clr_i  input  1  synchronous clear to 0
- load_i  input  1  synchronous load of load_val_i
- load_val_i  input  WIDTH  load value
- sat_i  input  1  1 = saturate at the range limit, 0 = wrap
- ovf_clr_i  input  1  clears ovf_o
- Q  output  WIDTH  registered count
- tc_o  output  1  terminal count, combinational from Q and up_i
- wrap_o  output  1  registered one-cycle pulse on a wrap or saturate event
- ovf_o  output  1  sticky overflow flag
- load_err_o  output  1  registered one-cycle pulse on an out-of-range load

Behaviour:
- Reset (async, RST=1): Q=0, wrap_o=0, ovf_o=0, load_err_o=0, prescaler=0. Takes effect immediately, including mid-count.
- Per-edge priority: clr_i > load_i > counting. en_i gates counting only.
- clr_i: Q<=0 regardless of en_i. ovf_o is unaffected.
- load_i:
  - load_val_i < MODULUS: Q<=load_val_i.
  - Otherwise: Q<=MODULUS-1 and load_err_o=1 for the next cycle.
- Count step (en_i=1, no clr_i, no load_i):
  - Up: Q<MODULUS-1 gives Q+1. At MODULUS-1, wrap mode gives 0; saturate mode holds.
  - Down: Q>0 gives Q-1. At 0, wrap mode gives MODULUS-1; saturate mode holds.
- Boundary event: an attempted step past the limit, in either mode.
  - wrap_o=1 in the cycle after the edge that handled the event (same edge Q updates).
  - ovf_o set on the same edge.
- tc_o = (up_i && Q==MODULUS-1) || (!up_i && Q==0). It is independent of en_i.
- Simultaneous ovf set and ovf_clr_i: set wins, ovf_o stays 1.
- Direction change mid-count takes effect on the next step, with no lost or extra count.
- MODULUS==2**WIDTH: natural binary wrap, so no compare overflow. Internal arithmetic uses WIDTH+1 bits.
- wrap_o and load_err_o are never asserted for more than one cycle per event.

Optional Feature:
- Macro: MOD_COUNTER_PRESCALE_EN
- Defined:
  - An internal prescaler of width clog2(PRESCALE) counts enabled cycles.
  - A count step occurs only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - clr_i or load_i resets the prescaler to 0.
  - en_i=0 freezes the prescaler.
  - PRESCALE=1 behaves as undefined.
- Undefined: no prescaler logic; every enabled cycle is a step; PRESCALE is ignored.

Test Plan:
- Reset mid-count: Q=7, assert RST between edges -> Q=0, ovf_o=0, wrap_o=0 immediately; count resumes from 0 after release.
- Up wrap (WIDTH=4, MODULUS=10, sat_i=0, en_i=1, up_i=1) from Q=0 for 12 edges -> Q sequence 1..9,0,1,2; tc_o=1 while Q=9; wrap_o pulses once, one cycle after Q=9; ovf_o=1.
- Down saturate (sat_i=1, up_i=0, load 2) then 4 enabled edges -> Q=1,0,0,0; wrap_o pulses twice (the two attempted steps at 0); ovf_clr_i asserted with a boundary event keeps ovf_o=1; ovf_clr_i alone clears it.
- Priority: clr_i=1, load_i=1, load_val_i=5, en_i=1 on one edge -> Q=0; next edge load_i=1 only -> Q=5; load_val_i=12 -> Q=9 and load_err_o pulses for 1 cycle.
- Direction flip: Q=4, up 2 steps, down 3 steps, en_i=0 for 2 cycles -> Q=5,6,5,4,3,3,3.
- With MOD_COUNTER_PRESCALE_EN, PRESCALE=4: 8 enabled cycles from Q=0 -> Q=1 after cycle 4, Q=2 after cycle 8; load mid-prescale restarts the 4-cycle interval.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter with clear, load, wrap/saturate mode and overflow flags.
// Optional prescaler enabled by defining MOD_COUNTER_PRESCALE_EN (step every PRESCALE enabled cycles).
module mod_n_updown_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 10,
  parameter int     PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             sat_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] Q,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             ovf_o,
  output logic             load_err_o
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

  logic             step;
  logic             at_limit;
  logic             boundary;
  logic             load_ok;
  logic [WIDTH-1:0] q_nxt;

  // One count step; arithmetic is WIDTH+1 bits so MODULUS == 2**WIDTH wraps naturally.
  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] q,
                                                   input logic up,
                                                   input logic sat,
                                                   input logic lim);
    logic [WIDTH:0] q_ext;
    q_ext = {1'b0, q};
    if (lim) begin
      step_value = sat ? q : (up ? '0 : Q_MAX);
    end else if (up) begin
      q_ext      = q_ext + (WIDTH+1)'(1);
      step_value = q_ext[WIDTH-1:0];
    end else begin
      q_ext      = q_ext - (WIDTH+1)'(1);
      step_value = q_ext[WIDTH-1:0];
    end
  endfunction

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps_q <= '0;
    end else if (clr_i || load_i) begin
      ps_q <= '0;
    end else if (en_i) begin
      ps_q <= (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
    end
  end

  assign step = en_i && (ps_q == PS_LAST);
`else
  assign step = en_i;
`endif

  always_comb begin
    at_limit = up_i ? (Q == Q_MAX) : (Q == '0);
    load_ok  = ({1'b0, load_val_i} < MOD_EXT);
    boundary = step && !clr_i && !load_i && at_limit;
    q_nxt    = Q;
    if (clr_i) begin
      q_nxt = '0;
    end else if (load_i) begin
      q_nxt = load_ok ? load_val_i : Q_MAX;
    end else if (step) begin
      q_nxt = step_value(Q, up_i, sat_i, at_limit);
    end
  end

  assign tc_o = at_limit;

  // Register stage: count, event pulses and sticky overflow
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q          <= '0;
      wrap_o     <= 1'b0;
      ovf_o      <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      Q          <= q_nxt;
      wrap_o     <= boundary;
      load_err_o <= load_i && !clr_i && !load_ok;
      if (boundary) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

endmodule
